vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Generates VGA raster timing and the pixel coordinates DrawX/DrawY plus the blank strobe.
//   It sits upstream of every sprite/palette renderer and of the VGA pins.
//   Renderers address their ROMs from DrawX/DrawY and pass RGB only while blank=1.
//   hs/vs drive the connector directly.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch (clocks)
//   H_SYNC    96   horizontal sync width (clocks)
//   H_BP      48   horizontal back porch (clocks)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch (lines)
//   V_SYNC    2    vertical sync width (lines)
//   V_BP      33   vertical back porch (lines)
// PORTS
//   vga_clk      in   1   pixel clock, 25 MHz nominal; all logic on posedge
//   reset_n      in   1   asynchronous, active-low reset
//   hs           out  1   horizontal sync, active low
//   vs           out  1   vertical sync, active low
//   blank        out  1   display enable: 1 = visible pixel, 0 = porch/sync
//   DrawX        out  10  current column; 0..H_TOTAL-1
//   DrawY        out  10  current row; 0..V_TOTAL-1
//   line_start   out  1   1-clk pulse when DrawX==0
//   frame_start  out  1   1-clk pulse when DrawX==0 && DrawY==0
//   frame_count  out  16  completed-frame counter, wraps 65535->0
// BEHAVIOUR
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be <= 1024.
//   - Internal state: hc, vc counters; h_phase, v_phase FSMs, each with states ACTIVE->FRONT->SYNC->BACK->ACTIVE.
//   - h_phase advances when hc reaches the last clock of the current phase. v_phase does the same on the last line.
//   - hc increments every clock; at H_TOTAL-1 it wraps to 0 and vc increments.
//   - At (H_TOTAL-1, V_TOTAL-1) both counters wrap to 0 and frame_count increments.
//   - All outputs are registered and mutually aligned: in any cycle, hs/vs/blank/pulses describe the pixel shown on DrawX/DrawY.
//   - Latency from counters to outputs is 1 clk.
//   - hs=0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751).
//   - vs=0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491). vs changes only together with DrawX==0.
//   - blank=1 iff DrawX<H_ACTIVE && DrawY<V_ACTIVE.
//   - DrawX/DrawY keep counting through porches. Consumers must gate on blank, not on coordinate range.
//   - Reset (async assert, any time incl. mid-line or inside sync):
//       hc=vc=0; FSMs=ACTIVE; DrawX=0, DrawY=0, blank=0, hs=1, vs=1;
//       line_start=0, frame_start=0, frame_count=0.
//   - First posedge after reset_n rises: outputs present (0,0) with blank=1, line_start=1, frame_start=1.
//     Counting proceeds from there; there is no partial frame.
//   - Sync polarity is fixed negative; no runtime reconfiguration.
// TESTING
//   1 Hold reset_n=0 for 5 clks -> DrawX=0, DrawY=0, blank=0, hs=vs=1, frame_count=0.
//     Release -> next clk (0,0) blank=1, frame_start=1.
//   2 Run one line -> blank=1 for DrawX 0..639, 0 for 640..799.
//     hs=0 exactly for DrawX 656..751 (96 clks); line_start period 800.
//   3 Line wrap: DrawX 799 -> 0 and DrawY n -> n+1 in the same clk.
//     At DrawY=479->480, blank stays 0 for the whole line 480.
//   4 Full frame -> vs=0 for DrawY 490..491 (1600 clks).
//     At (799,524) the next clk gives (0,0), frame_start=1, frame_count 0->1; frame period 420000 clks.
//   5 Assert reset_n=0 at DrawX=700 (hs low) on DrawY=491 (vs low) -> hs=vs=1 and blank=0 immediately (async).
//     After release, the sequence restarts as in scenario 1.
//   6 Params H 8/2/2/2, V 4/1/1/1 -> H_TOTAL 14, V_TOTAL 7.
//     hs low at DrawX 10..11, vs low at DrawY 5; run 3 frames, check frame_count=3.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle from vga_timing_gen to renderers and the VGA connector.
// master drives the timing; slave is any consumer.
interface vga_timing_gen_if;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
    );
    modport slave (
        input hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: hc/vc counters with phase FSMs, and one register stage
// that presents coordinates, syncs, blank and pulses for the same pixel.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    // Advance to the next phase when the counter sits on the last count of the current one.
    function automatic phase_e next_phase(
        input phase_e     ph,
        input logic [9:0] cnt,
        input logic [9:0] act_end,
        input logic [9:0] fp_end,
        input logic [9:0] sync_end,
        input logic [9:0] last_cnt
    );
        next_phase = ph;
        case (ph)
            PH_ACTIVE: if (cnt == act_end)  next_phase = PH_FRONT;
            PH_FRONT:  if (cnt == fp_end)   next_phase = PH_SYNC;
            PH_SYNC:   if (cnt == sync_end) next_phase = PH_BACK;
            PH_BACK:   if (cnt == last_cnt) next_phase = PH_ACTIVE;
            default:                        next_phase = PH_ACTIVE;
        endcase
    endfunction

    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    phase_e      h_phase_q, h_phase_d;
    phase_e      v_phase_q, v_phase_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [9:0]  draw_x_q, draw_x_d;
    logic [9:0]  draw_y_q, draw_y_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        h_last;
    logic        v_last;

    always_comb begin
        h_last = (hc_q == H_LAST);
        v_last = (vc_q == V_LAST);

        hc_d = h_last ? 10'd0 : hc_q + 10'd1;
        vc_d = vc_q;
        if (h_last) begin
            vc_d = v_last ? 10'd0 : vc_q + 10'd1;
        end

        frame_cnt_d = frame_cnt_q;
        if (h_last && v_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        h_phase_d = next_phase(h_phase_q, hc_q, H_ACT_END, H_FP_END, H_SYNC_END, H_LAST);
        v_phase_d = v_phase_q;
        if (h_last) begin
            v_phase_d = next_phase(v_phase_q, vc_q, V_ACT_END, V_FP_END, V_SYNC_END, V_LAST);
        end

        // Output stage samples the current counter state, so everything it
        // presents lines up with DrawX/DrawY one clock later. frame_cnt_q
        // already holds the new value when the counters sit on (0,0).
        draw_x_d      = hc_q;
        draw_y_d      = vc_q;
        hs_d          = (h_phase_q != PH_SYNC);
        vs_d          = (v_phase_q != PH_SYNC);
        blank_d       = (h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE);
        line_start_d  = (hc_q == 10'd0);
        frame_start_d = (hc_q == 10'd0) && (vc_q == 10'd0);
        frame_count_d = frame_cnt_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            h_phase_q     <= PH_ACTIVE;
            v_phase_q     <= PH_ACTIVE;
            frame_cnt_q   <= 16'd0;
            draw_x_q      <= 10'd0;
            draw_y_q      <= 10'd0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            h_phase_q     <= h_phase_d;
            v_phase_q     <= v_phase_d;
            frame_cnt_q   <= frame_cnt_d;
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.blank       = blank_q;
    assign vga.DrawX       = draw_x_q;
    assign vga.DrawY       = draw_y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 800-clock lines with a short frame
// (12/10/2/3 lines) plus a tiny 14x7 raster run for three frames.
module tb_vga_timing_gen;

    // Short vertical timing keeps full-frame runs small; expected values derive from these.
    localparam int MV_ACT  = 12;
    localparam int MV_FP   = 10;
    localparam int MV_SYNC = 2;
    localparam int MV_BP   = 3;
    localparam int MV_TOT  = MV_ACT + MV_FP + MV_SYNC + MV_BP;  // 27
    localparam int MH_TOT  = 800;

    logic clk = 1'b0;
    logic rst_m_n = 1'b0;
    logic rst_s_n = 1'b0;
    always #20 clk = ~clk;

    vga_timing_gen_if m_if ();
    vga_timing_gen_if s_if ();

    vga_timing_gen #(
        .V_ACTIVE(MV_ACT), .V_FP(MV_FP), .V_SYNC(MV_SYNC), .V_BP(MV_BP)
    ) dut_m (
        .vga_clk(clk),
        .reset_n(rst_m_n),
        .vga    (m_if)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_s (
        .vga_clk(clk),
        .reset_n(rst_s_n),
        .vga    (s_if)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int xerr, berr, herr, verr, bcnt, hcnt, hfirst, hlast, lscnt;
    int vcnt, vfirst, vlast, vchg, f0, f1, fc_before;
    logic prev_vs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        // 1: reset held for 5 clocks, then release
        step(5);
        chk("rst_x", 32'(m_if.DrawX), 0);
        chk("rst_y", 32'(m_if.DrawY), 0);
        chk("rst_blank", 32'(m_if.blank), 0);
        chk("rst_hs", 32'(m_if.hs), 1);
        chk("rst_vs", 32'(m_if.vs), 1);
        chk("rst_fc", 32'(m_if.frame_count), 0);
        chk("rst_ls", 32'(m_if.line_start), 0);
        chk("rst_fs", 32'(m_if.frame_start), 0);
        rst_m_n = 1'b1;
        step(1);
        chk("rel_x", 32'(m_if.DrawX), 0);
        chk("rel_y", 32'(m_if.DrawY), 0);
        chk("rel_blank", 32'(m_if.blank), 1);
        chk("rel_fs", 32'(m_if.frame_start), 1);
        chk("rel_ls", 32'(m_if.line_start), 1);
        f0 = cyc;

        // 2: one full line
        xerr = 0; berr = 0; bcnt = 0; hcnt = 0; hfirst = -1; hlast = -1; lscnt = 0;
        for (int i = 0; i < MH_TOT; i++) begin
            if (m_if.DrawX !== 10'(i) || m_if.DrawY !== 10'd0) xerr++;
            if (m_if.blank !== (i < 640)) berr++;
            if (m_if.blank === 1'b1) bcnt++;
            if (m_if.hs === 1'b0) begin
                hcnt++;
                if (hfirst < 0) hfirst = i;
                hlast = i;
            end
            if (m_if.line_start === 1'b1) lscnt++;
            step(1);
        end
        chk("line_coord_err", 32'(xerr), 0);
        chk("line_blank_err", 32'(berr), 0);
        chk("line_blank_cnt", 32'(bcnt), 640);
        chk("line_hs_cnt", 32'(hcnt), 96);
        chk("line_hs_first", 32'(hfirst), 656);
        chk("line_hs_last", 32'(hlast), 751);
        chk("line_ls_cnt", 32'(lscnt), 1);
        chk("wrap1_x", 32'(m_if.DrawX), 0);
        chk("wrap1_y", 32'(m_if.DrawY), 1);
        chk("wrap1_ls", 32'(m_if.line_start), 1);
        chk("wrap1_fs", 32'(m_if.frame_start), 0);

        // 3: last active line to first blank line
        step((MV_ACT - 2) * MH_TOT + MH_TOT - 1);
        chk("pre_vb_x", 32'(m_if.DrawX), 799);
        chk("pre_vb_y", 32'(m_if.DrawY), MV_ACT - 1);
        step(1);
        chk("vb_x", 32'(m_if.DrawX), 0);
        chk("vb_y", 32'(m_if.DrawY), MV_ACT);
        bcnt = 0;
        for (int i = 0; i < MH_TOT; i++) begin
            if (m_if.blank !== 1'b0) bcnt++;
            step(1);
        end
        chk("vb_line_blank", 32'(bcnt), 0);

        // 4: rest of frame, vsync window, frame wrap
        vcnt = 0; vfirst = -1; vlast = -1; vchg = 0; fc_before = -1;
        prev_vs = m_if.vs;
        for (int i = 0; i < (MV_TOT - MV_ACT - 1) * MH_TOT; i++) begin
            if (m_if.vs === 1'b0) begin
                vcnt++;
                if (vfirst < 0) vfirst = int'(m_if.DrawY);
                vlast = int'(m_if.DrawY);
            end
            if (m_if.vs !== prev_vs && m_if.DrawX !== 10'd0) vchg++;
            prev_vs = m_if.vs;
            fc_before = int'(m_if.frame_count);
            step(1);
        end
        chk("vs_cnt", 32'(vcnt), MV_SYNC * MH_TOT);
        chk("vs_first", 32'(vfirst), MV_ACT + MV_FP);
        chk("vs_last", 32'(vlast), MV_ACT + MV_FP + MV_SYNC - 1);
        chk("vs_mid_line_chg", 32'(vchg), 0);
        chk("fc_before_wrap", 32'(fc_before), 0);
        chk("fwrap_x", 32'(m_if.DrawX), 0);
        chk("fwrap_y", 32'(m_if.DrawY), 0);
        chk("fwrap_fs", 32'(m_if.frame_start), 1);
        chk("fwrap_fc", 32'(m_if.frame_count), 1);
        f1 = cyc;
        chk("frame_period", 32'(f1 - f0), MV_TOT * MH_TOT);

        // 5: async reset inside hsync and vsync
        step((MV_ACT + MV_FP + MV_SYNC - 1) * MH_TOT + 700);
        chk("mid_x", 32'(m_if.DrawX), 700);
        chk("mid_y", 32'(m_if.DrawY), MV_ACT + MV_FP + MV_SYNC - 1);
        chk("mid_hs", 32'(m_if.hs), 0);
        chk("mid_vs", 32'(m_if.vs), 0);
        #5 rst_m_n = 1'b0;
        #1;
        chk("arst_hs", 32'(m_if.hs), 1);
        chk("arst_vs", 32'(m_if.vs), 1);
        chk("arst_blank", 32'(m_if.blank), 0);
        chk("arst_x", 32'(m_if.DrawX), 0);
        chk("arst_y", 32'(m_if.DrawY), 0);
        chk("arst_fc", 32'(m_if.frame_count), 0);
        step(3);
        chk("arst_hold_x", 32'(m_if.DrawX), 0);
        chk("arst_hold_blank", 32'(m_if.blank), 0);
        rst_m_n = 1'b1;
        step(1);
        chk("rerel_x", 32'(m_if.DrawX), 0);
        chk("rerel_y", 32'(m_if.DrawY), 0);
        chk("rerel_blank", 32'(m_if.blank), 1);
        chk("rerel_fs", 32'(m_if.frame_start), 1);
        chk("rerel_ls", 32'(m_if.line_start), 1);
        step(1);
        chk("rerel_x1", 32'(m_if.DrawX), 1);
        chk("rerel_fs1", 32'(m_if.frame_start), 0);
        chk("rerel_ls1", 32'(m_if.line_start), 0);

        // 6: tiny raster, three frames
        chk("s_rst_hs", 32'(s_if.hs), 1);
        chk("s_rst_blank", 32'(s_if.blank), 0);
        rst_s_n = 1'b1;
        step(1);
        xerr = 0; berr = 0; herr = 0; verr = 0; lscnt = 0;
        for (int i = 0; i < 3 * 14 * 7; i++) begin
            if (s_if.DrawX !== 10'(i % 14) || s_if.DrawY !== 10'((i / 14) % 7)) xerr++;
            if (s_if.hs !== !((i % 14) >= 10 && (i % 14) <= 11)) herr++;
            if (s_if.vs !== !(((i / 14) % 7) == 5)) verr++;
            if (s_if.blank !== ((i % 14) < 8 && ((i / 14) % 7) < 4)) berr++;
            if (s_if.frame_count !== 16'(i / 98)) lscnt++;
            step(1);
        end
        chk("s_coord_err", 32'(xerr), 0);
        chk("s_hs_err", 32'(herr), 0);
        chk("s_vs_err", 32'(verr), 0);
        chk("s_blank_err", 32'(berr), 0);
        chk("s_fc_err", 32'(lscnt), 0);
        chk("s_end_x", 32'(s_if.DrawX), 0);
        chk("s_end_y", 32'(s_if.DrawY), 0);
        chk("s_end_fs", 32'(s_if.frame_start), 1);
        chk("s_fc3", 32'(s_if.frame_count), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
